fifo_multi_mode: RTL and testbench
==================================

Name: fifo_multi_mode

Overview:
- Parametrised successor to the team's single-clock synchronous FIFO, used as the general-purpose buffer between pixel and line pipeline stages in the VGA datapath.
- Adds:
  - a compile-time selectable read mode: standard registered read, or first-word-fall-through (FWFT);
  - a full-range occupancy count;
  - programmable almost-full and almost-empty flags;
  - a synchronous flush;
  - sticky overflow and underflow error flags.

Parameters:
- DATA_WIDTH, 32, width of each stored word.
- ADDR_WIDTH, 4, log2 of depth. Depth = 2**ADDR_WIDTH; no separate depth parameter.
- FWFT, 0, read mode. 0 = standard registered read; 1 = first-word-fall-through.
- AF_LEVEL, 2**ADDR_WIDTH-2, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.

Ports:
- clk  in  1  Rising-edge clock for all state.
- rst_n  in  1  Asynchronous active-low reset.
- flush  in  1  Synchronous clear of contents. Memory contents are not cleared.
- wren  in  1  Write request.
- wdat  in  DATA_WIDTH  Write data.
- rden  in  1  Read request (standard mode) or pop/acknowledge (FWFT mode).
- rdat  out  DATA_WIDTH  Read data.
- rvld  out  1  rdat valid.
- full  out  1  No free entries.
- empty  out  1  No stored entries.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  ADDR_WIDTH+1  Occupancy, 0..2**ADDR_WIDTH.
- clr_err  in  1  Synchronous clear of both sticky error flags.
- overflow  out  1  Sticky: a write was attempted while full.
- underflow  out  1  Sticky: a read was attempted while empty.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Pointers, count, rdat, rvld, overflow and underflow clear to 0.
  - empty=1, full=0, almost_empty=1, almost_full=0.
  - Reset mid-transfer discards all data immediately.
  - Memory array is not reset.
- Pointers are ADDR_WIDTH+1 bits; the MSB is the wrap bit.
  - empty = pointers equal.
  - full = MSBs differ and low bits equal.
  - count = wr_ptr - rd_ptr, modulo 2**(ADDR_WIDTH+1). count = 2**ADDR_WIDTH when full.
- Accepting requests:
  - A write is accepted iff wren && !full.
  - A read is accepted iff rden && !empty.
  - Both are evaluated on the current-cycle flags.
  - Write while full: data dropped, no pointer change, overflow set.
  - Read while empty: no pointer change, underflow set. In standard mode rvld stays 0.
- Simultaneous read and write:
  - Not empty and not full: both accepted, count unchanged.
  - Full: read accepted, write rejected, overflow set.
  - Empty: write accepted, read rejected, underflow set.
- Flags, count, almost_full and almost_empty are registered or derived from registered pointers. All update in the cycle after the accepted operation.
- Standard mode (FWFT=0):
  - An accepted read drives the head word on rdat with rvld=1 one cycle later.
  - In any cycle without an accepted read on the previous edge, rdat=0 and rvld=0.
  - Back-to-back reads give one word per cycle.
- FWFT mode (FWFT=1):
  - rvld = !empty; rdat = head word whenever rvld=1, and 0 otherwise.
  - rden while rvld=1 pops the head. The next word (or empty) is presented the following cycle.
  - Write to an empty FIFO: rvld rises one cycle after the write edge, with rdat = that word.
  - count includes the presented head word.
- Flush:
  - Sets rd_ptr = wr_ptr = 0 on the next edge. Output is then empty=1, count=0, rvld=0, rdat=0.
  - Flush has priority over a same-cycle wren and rden; both are ignored and no error flags are set.
- clr_err:
  - Clears overflow and underflow on the next edge.
  - A same-cycle error event takes priority, so the flag remains set.
- Thresholds are compared against the registered count with unsigned arithmetic.
  - AF_LEVEL and AE_LEVEL outside 0..2**ADDR_WIDTH are illegal; flag them with a simulation-time assertion.

Test Plan:
- Reset then idle, FWFT=0, ADDR_WIDTH=4 -> empty=1, count=0, almost_empty=1, rvld=0, rdat=0, overflow=0, underflow=0.
- Write 16 words 0x00..0x0F, then one more write of 0xAA:
  - full=1, count=16, almost_full=1 from count 14 onward, overflow=1.
  - Then 16 back-to-back reads return 0x00..0x0F with rvld=1, each one cycle after its rden.
  - 0xAA never appears; empty=1 afterwards.
- Wrap-around with a simultaneous read and write at count=8 for 40 cycles:
  - count stays 8 and data order is preserved across pointer wrap.
  - Then rden on empty -> underflow=1; clr_err -> underflow=0 the next cycle.
- FWFT=1, write 0x1234 into empty FIFO:
  - rvld=1 and rdat=0x1234 the next cycle with no rden.
  - rden pops it, and rvld=0 the following cycle.
- Write 10 words, assert flush together with wren=1 and rden=1 -> next cycle count=0, empty=1, no error flags set.
- Assert rst_n low asynchronously, mid-burst, between clock edges -> all outputs reach reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fifo_multi_mode.sv
// Single-clock FIFO with compile-time standard/FWFT read mode, occupancy count,
// programmable almost flags, synchronous flush and sticky overflow/underflow flags.
module fifo_multi_mode #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int FWFT       = 0,
    parameter int AF_LEVEL   = 2**ADDR_WIDTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wren,
    input  logic [DATA_WIDTH-1:0] wdat,
    input  logic                  rden,
    output logic [DATA_WIDTH-1:0] rdat,
    output logic                  rvld,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    input  logic                  clr_err,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] AF_THR = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_THR = (ADDR_WIDTH+1)'(AE_LEVEL);
    localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] rdat_q, rdat_d;
    logic                  rvld_q, rvld_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;

    logic                  empty_w, full_w, wr_acc, rd_acc;
    logic [ADDR_WIDTH:0]   count_w;
    logic [DATA_WIDTH-1:0] head_w;

    // The pointer MSB is a wrap bit, so full and empty differ only in that bit.
    assign empty_w = (wr_ptr_q == rd_ptr_q);
    assign full_w  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                     (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    assign count_w = wr_ptr_q - rd_ptr_q;
    assign head_w  = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];

    assign wr_acc = wren && !full_w && !flush;
    assign rd_acc = rden && !empty_w && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        rdat_d   = '0;
        rvld_d   = 1'b0;
        ovf_d    = clr_err ? 1'b0 : ovf_q;
        udf_d    = clr_err ? 1'b0 : udf_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                rdat_d   = head_w;
                rvld_d   = 1'b1;
            end
            // A new error event wins over a same-cycle clear.
            if (wren && full_w)  ovf_d = 1'b1;
            if (rden && empty_w) udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rdat_q   <= '0;
            rvld_q   <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rdat_q   <= rdat_d;
            rvld_q   <= rvld_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wdat;
    end

    // FWFT presents the head combinationally from the registered read pointer.
    assign rdat = (FWFT != 0) ? (empty_w ? '0 : head_w) : rdat_q;
    assign rvld = (FWFT != 0) ? !empty_w : rvld_q;

    assign empty        = empty_w;
    assign full         = full_w;
    assign count        = count_w;
    assign almost_full  = (count_w >= AF_THR);
    assign almost_empty = (count_w <= AE_THR);
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    always_ff @(posedge clk) begin
        assert (AF_LEVEL >= 0 && AF_LEVEL <= DEPTH)
            else $error("fifo_multi_mode: AF_LEVEL out of range");
        assert (AE_LEVEL >= 0 && AE_LEVEL <= DEPTH)
            else $error("fifo_multi_mode: AE_LEVEL out of range");
    end
endmodule

// File: tb/tb_fifo_multi_mode.sv
// Bench for fifo_multi_mode: one standard-mode and one FWFT-mode instance,
// directed stimulus with a queue-based scoreboard and separate read monitors.
module tb_fifo_multi_mode;
  localparam int DW = 32;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          s_flush = 0, s_wren = 0, s_rden = 0, s_clr = 0;
  logic [DW-1:0] s_wdat = '0, s_rdat;
  logic          s_rvld, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic [AW:0]   s_count;

  logic          f_flush = 0, f_wren = 0, f_rden = 0, f_clr = 0;
  logic [DW-1:0] f_wdat = '0, f_rdat;
  logic          f_rvld, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [AW:0]   f_count;

  fifo_multi_mode #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .flush(s_flush), .wren(s_wren), .wdat(s_wdat),
    .rden(s_rden), .rdat(s_rdat), .rvld(s_rvld), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count), .clr_err(s_clr),
    .overflow(s_ovf), .underflow(s_udf)
  );

  fifo_multi_mode #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .flush(f_flush), .wren(f_wren), .wdat(f_wdat),
    .rden(f_rden), .rdat(f_rdat), .rvld(f_rvld), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count), .clr_err(f_clr),
    .overflow(f_ovf), .underflow(f_udf)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] fexp_q[$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Standard-mode monitor: every rvld must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && s_rvld) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL std_unexpected_rvld: got rdat %h expected no rvld", s_rdat);
      end else begin
        check("std_rdat", s_rdat, exp_q.pop_front());
      end
    end
  end

  // FWFT monitor: compare the presented head whenever it is being popped.
  always @(negedge clk) begin
    if (rst_n && f_rvld && f_rden) begin
      if (fexp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL fwft_unexpected_pop: got rdat %h expected no data", f_rdat);
      end else begin
        check("fwft_rdat", f_rdat, fexp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();

    // Reset / idle state
    check("rst_empty", 32'(s_empty), 32'd1);
    check("rst_full", 32'(s_full), 32'd0);
    check("rst_count", 32'(s_count), 32'd0);
    check("rst_ae", 32'(s_ae), 32'd1);
    check("rst_af", 32'(s_af), 32'd0);
    check("rst_rvld", 32'(s_rvld), 32'd0);
    check("rst_rdat", s_rdat, 32'd0);
    check("rst_ovf", 32'(s_ovf), 32'd0);
    check("rst_udf", 32'(s_udf), 32'd0);
    check("rst_f_rvld", 32'(f_rvld), 32'd0);

    // Fill 16 words, watching count and almost flags
    for (int i = 0; i < 16; i++) begin
      s_wren = 1; s_wdat = 32'(i);
      exp_q.push_back(32'(i));
      cyc();
      check("fill_count", 32'(s_count), 32'(i + 1));
      check("fill_af", 32'(s_af), 32'((i + 1) >= 14));
      check("fill_ae", 32'(s_ae), 32'((i + 1) <= 2));
    end
    s_wdat = 32'hAA;
    cyc();
    s_wren = 0;
    check("ovf_full", 32'(s_full), 32'd1);
    check("ovf_count", 32'(s_count), 32'd16);
    check("ovf_flag", 32'(s_ovf), 32'd1);
    check("ovf_af", 32'(s_af), 32'd1);

    // Drain with back-to-back reads
    s_rden = 1;
    repeat (16) cyc();
    s_rden = 0;
    cyc();
    check("drain_empty", 32'(s_empty), 32'd1);
    check("drain_count", 32'(s_count), 32'd0);
    check("drain_q_left", 32'(exp_q.size()), 32'd0);
    check("drain_udf", 32'(s_udf), 32'd0);

    // Wrap-around: hold occupancy at 8 with simultaneous read/write
    for (int i = 0; i < 8; i++) begin
      s_wren = 1; s_wdat = 32'h100 + 32'(i);
      exp_q.push_back(s_wdat);
      cyc();
    end
    s_rden = 1;
    for (int k = 0; k < 40; k++) begin
      s_wdat = 32'h200 + 32'(k);
      exp_q.push_back(s_wdat);
      cyc();
      check("wrap_count", 32'(s_count), 32'd8);
    end
    s_wren = 0;
    repeat (8) cyc();
    cyc();
    s_rden = 0;
    check("udf_set", 32'(s_udf), 32'd1);
    check("udf_empty", 32'(s_empty), 32'd1);
    check("wrap_q_left", 32'(exp_q.size()), 32'd0);
    s_clr = 1;
    cyc();
    s_clr = 0;
    check("clr_udf", 32'(s_udf), 32'd0);
    check("clr_ovf", 32'(s_ovf), 32'd0);

    // Flush beats same-cycle write and read
    for (int i = 0; i < 10; i++) begin
      s_wren = 1; s_wdat = 32'h300 + 32'(i);
      cyc();
    end
    check("pre_flush_count", 32'(s_count), 32'd10);
    s_flush = 1; s_rden = 1;
    cyc();
    s_flush = 0; s_rden = 0; s_wren = 0;
    check("flush_count", 32'(s_count), 32'd0);
    check("flush_empty", 32'(s_empty), 32'd1);
    check("flush_ovf", 32'(s_ovf), 32'd0);
    check("flush_udf", 32'(s_udf), 32'd0);
    check("flush_rvld", 32'(s_rvld), 32'd0);
    s_wren = 1; s_wdat = 32'h55;
    exp_q.push_back(32'h55);
    cyc();
    s_wren = 0; s_rden = 1;
    cyc();
    s_rden = 0;
    cyc();
    check("post_flush_q_left", 32'(exp_q.size()), 32'd0);

    // FWFT: single word falls through without rden
    f_wren = 1; f_wdat = 32'h1234;
    fexp_q.push_back(32'h1234);
    cyc();
    f_wren = 0;
    check("fwft_rvld", 32'(f_rvld), 32'd1);
    check("fwft_head", f_rdat, 32'h1234);
    check("fwft_count", 32'(f_count), 32'd1);
    cyc();
    check("fwft_hold", f_rdat, 32'h1234);
    f_rden = 1;
    cyc();
    f_rden = 0;
    check("fwft_pop_rvld", 32'(f_rvld), 32'd0);
    check("fwft_pop_rdat", f_rdat, 32'd0);
    check("fwft_pop_empty", 32'(f_empty), 32'd1);
    check("fwft_udf", 32'(f_udf), 32'd0);

    // FWFT: burst of three, popped back-to-back
    for (int i = 0; i < 3; i++) begin
      f_wren = 1; f_wdat = 32'hC0 + 32'(i);
      fexp_q.push_back(f_wdat);
      cyc();
    end
    f_wren = 0;
    check("fwft_count3", 32'(f_count), 32'd3);
    f_rden = 1;
    repeat (3) cyc();
    f_rden = 0;
    check("fwft_burst_q_left", 32'(fexp_q.size()), 32'd0);
    check("fwft_burst_empty", 32'(f_empty), 32'd1);

    // Asynchronous reset mid-burst
    for (int i = 0; i < 4; i++) begin
      s_wren = 1; s_wdat = 32'h400 + 32'(i);
      exp_q.push_back(s_wdat);
      f_wren = 1; f_wdat = 32'h500 + 32'(i);
      cyc();
    end
    s_wren = 0; f_wren = 0;
    s_rden = 1;
    cyc();
    cyc();
    check("pre_rst_rvld", 32'(s_rvld), 32'd1);
    check("pre_rst_f_rvld", 32'(f_rvld), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", 32'(s_count), 32'd0);
    check("arst_empty", 32'(s_empty), 32'd1);
    check("arst_full", 32'(s_full), 32'd0);
    check("arst_ae", 32'(s_ae), 32'd1);
    check("arst_af", 32'(s_af), 32'd0);
    check("arst_rvld", 32'(s_rvld), 32'd0);
    check("arst_rdat", s_rdat, 32'd0);
    check("arst_f_rvld", 32'(f_rvld), 32'd0);
    check("arst_f_rdat", f_rdat, 32'd0);
    check("arst_f_count", 32'(f_count), 32'd0);
    exp_q.delete();
    fexp_q.delete();
    s_rden = 0;
    cyc();
    rst_n = 1'b1;
    cyc();
    check("post_rst_empty", 32'(s_empty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
